// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the shift-add multiplier sequencer.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Iteration counter width for a given operand width.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_mult_fsm.sv
// Control FSM for the shift-add multiplier: state register, iteration counter,
// handshake outputs and the load/step/done enable strobes for the datapath.
module seq_mult_fsm
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic out_ready,
  input  logic early_exit,
  output logic in_ready,
  output logic out_valid,
  output logic busy,
  output logic load,
  output logic step,
  output logic done
);

  localparam int CW = cnt_w(WIDTH);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          last;

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, counter update, handshake outputs and datapath strobes.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    done       = 1'b0;
    last       = (cnt == CW'(WIDTH - 1)) || early_exit;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load       = 1'b1;
          cnt_next   = '0;
          state_next = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        step = 1'b1;
        // Counter holds on the final iteration so it never wraps.
        if (last) begin
          done       = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Shift-add multiplier sequencer: accepts an operand pair, iterates one partial
// product per clock, and returns the 2*WIDTH-bit product over valid/ready.
// Optional build macro SEQ_MULT_EARLY_EXIT_EN finishes as soon as the remaining
// multiplier bits are all zero.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] product_q;
  logic [WIDTH-1:0]   mplier;
  logic               load;
  logic               step;
  logic               done;
  logic               early_exit;

`ifdef SEQ_MULT_EARLY_EXIT_EN
  assign early_exit = (mplier[WIDTH-1:1] == '0);
`else
  assign early_exit = 1'b0;
`endif

  assign acc_sum = acc + (mplier[0] ? mcand : '0);
  assign product = product_q;

  seq_mult_fsm #(
    .WIDTH(WIDTH)
  ) u_fsm (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .early_exit(early_exit),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .busy      (busy),
    .load      (load),
    .step      (step),
    .done      (done)
  );

  // Multiplicand register: loaded zero-extended, shifted left each iteration.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand <= '0;
    end else if (load) begin
      mcand <= {{WIDTH{1'b0}}, op_a};
    end else if (step) begin
      mcand <= mcand << 1;
    end
  end

  // Multiplier register: loaded with op_b, shifted right each iteration.
  always_ff @(posedge clk) begin
    if (reset) begin
      mplier <= '0;
    end else if (load) begin
      mplier <= op_b;
    end else if (step) begin
      mplier <= mplier >> 1;
    end
  end

  // Accumulator: cleared on load, adds the multiplicand when the LSB is set.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (load) begin
      acc <= '0;
    end else if (step) begin
      acc <= acc_sum;
    end
  end

  // Product register: captures the final sum so it survives the next load.
  always_ff @(posedge clk) begin
    if (reset) begin
      product_q <= '0;
    end else if (done) begin
      product_q <= acc_sum;
    end
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed and random checks of seq_mult_ctrl using an in-order result queue.
module tb_seq_mult_ctrl;

  localparam int W = 8;

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;

  logic [2*W-1:0] exp_q[$];
  int             errors = 0;
  int             checks = 0;
  int             received = 0;

  seq_mult_ctrl #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product  (product),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Expected cycles from accepting edge to out_valid.
  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef SEQ_MULT_EARLY_EXIT_EN
    int m = 0;
    for (int i = 0; i < W; i++) if (b[i]) m = i;
    return m + 1;
`else
    return W;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operand pair until accepted; queue the expected product if asked.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit keep);
    int n = 0;
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("accept_wait", (n < 100), 1);
    if (keep) exp_q.push_back((2*W)'(a) * (2*W)'(b));
    tick();
    in_valid = 1'b0;
  endtask

  // Wait for a result, optionally stall it, then take it and compare in order.
  task automatic receive(input int gap, input int lat_exp, input bit noise, input string tag);
    int             lat = 0;
    logic [2*W-1:0] held;
    logic [2*W-1:0] want;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, lat_exp);
    check({tag, "_queue"}, (exp_q.size() > 0), 1);
    want = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    held = product;
    if (noise) begin
      in_valid = 1'b1;
      op_a     = 8'd7;
      op_b     = 8'd7;
    end
    for (int i = 0; i < gap; i++) begin
      tick();
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_product"}, product, held);
      check({tag, "_hold_in_ready"}, in_ready, 0);
    end
    in_valid = 1'b0;
    check({tag, "_product"}, product, want);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    received++;
    check({tag, "_after_valid"}, out_valid, 0);
    check({tag, "_after_in_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] a;
    logic [W-1:0] b;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    tick();
    tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 0);
    reset = 1'b0;
    tick();

    // Basic product and latency.
    send(8'd13, 8'd11, 1'b1);
    receive(0, exp_lat(8'd11), 1'b0, "t2");
    check("t2_idle_hold", product, 16'd143);

    // Reset in the middle of an operation drops it.
    send(8'd3, 8'd5, 1'b0);
    tick();
    tick();
    check("t1_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t1_in_ready", in_ready, 1);
    check("t1_out_valid", out_valid, 0);
    check("t1_busy_after", busy, 0);
    check("t1_product", product, 0);
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check("t1_no_output", out_valid, 0);
    end

    // Extremes.
    send(8'd255, 8'd255, 1'b1);
    receive(0, exp_lat(8'd255), 1'b0, "t3_ff");
    check("t3_fe01", product, 16'hFE01);
    send(8'd0, 8'h77, 1'b1);
    receive(0, exp_lat(8'h77), 1'b0, "t3_a0");
    send(8'h77, 8'd0, 1'b1);
    receive(0, exp_lat(8'd0), 1'b0, "t3_b0");
    send(8'd1, 8'd200, 1'b1);
    receive(0, exp_lat(8'd200), 1'b0, "t3_one");
    check("t3_200", product, 16'd200);

    // Back-pressure with ignored operands, then confirm nothing was accepted.
    send(8'd200, 8'd3, 1'b1);
    receive(20, exp_lat(8'd3), 1'b1, "t4");
    send(8'd5, 8'd6, 1'b1);
    receive(0, exp_lat(8'd6), 1'b0, "t4_next");

`ifdef SEQ_MULT_EARLY_EXIT_EN
    send(8'd9, 8'd0, 1'b1);
    receive(0, 1, 1'b0, "t5_x0");
    send(8'd9, 8'd1, 1'b1);
    receive(0, 1, 1'b0, "t5_x1");
    send(8'd9, 8'd6, 1'b1);
    receive(0, 3, 1'b0, "t5_x6");
    send(8'd9, 8'd128, 1'b1);
    receive(0, 8, 1'b0, "t5_x128");
`endif

    // Random stream with idle gaps and output stalls.
    received = 0;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) a = '1;
      if ($urandom_range(0, 15) == 0) b = '1;
      repeat ($urandom_range(0, 3)) tick();
      send(a, b, 1'b1);
      receive($urandom_range(0, 3), exp_lat(b), ($urandom_range(0, 3) == 0), "t6");
    end
    check("t6_count", received, 1000);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
